// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit encoding, program-loader states and helpers.
package ternary_pkg;

   // Two-bit trit encoding; 2'b11 is not a legal trit.
   typedef logic [1:0] trit_t;

   localparam trit_t T_ZERO    = 2'b00;
   localparam trit_t T_POS_ONE = 2'b01;
   localparam trit_t T_NEG_ONE = 2'b10;

   // Program-loader framing constants.
   localparam logic [7:0] LDR_SYNC           = 8'hA5;
   localparam int         LDR_BYTES_PER_INSN = 3;

   // Loader frame-parser states.
   typedef enum logic [3:0] {
      LDR_IDLE = 4'd0,
      LDR_CNT  = 4'd1,
      LDR_B0   = 4'd2,
      LDR_B1   = 4'd3,
      LDR_B2   = 4'd4,
      LDR_WR   = 4'd5,
      LDR_CSUM = 4'd6,
      LDR_DONE = 4'd7,
      LDR_ERR  = 4'd8
   } loader_state_t;

   // True when a 2-bit field is one of the three legal trit codes.
   function automatic logic trit_code_valid(input logic [1:0] code);
      return (code == T_NEG_ONE) || (code == T_ZERO) || (code == T_POS_ONE);
   endfunction

endpackage

// File: rtl/ternary_insn_unpack.sv
// Combinational unpacker: three packed bytes -> one 9-trit instruction word.
// byte0 carries trits 3..0, byte1 trits 7..4, byte2[1:0] trit 8; byte2[7:2]
// must be zero. fmt_err flags any illegal trit code or stray upper bits.
module ternary_insn_unpack
   import ternary_pkg::*;
(
   input  logic        [7:0] byte0,
   input  logic        [7:0] byte1,
   input  logic        [7:0] byte2,
   output trit_t       [8:0] word,
   output logic              fmt_err
);

   logic [8:0] code_ok;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign word[gi]        = byte0[2*gi +: 2];
         assign word[gi + 4]    = byte1[2*gi +: 2];
         assign code_ok[gi]     = trit_code_valid(byte0[2*gi +: 2]);
         assign code_ok[gi + 4] = trit_code_valid(byte1[2*gi +: 2]);
      end
   endgenerate

   assign word[8]    = byte2[1:0];
   assign code_ok[8] = trit_code_valid(byte2[1:0]);

   assign fmt_err = (~&code_ok) | (|byte2[7:2]);

endmodule

// File: rtl/ternary_prog_loader.sv
// Program-image loader: parses SYNC/COUNT/payload/CSUM frames from a byte
// stream and writes each unpacked 9-trit instruction to instruction memory.
module ternary_prog_loader
   import ternary_pkg::*;
#(
   parameter int         IMEM_DEPTH = 243,
   parameter logic [7:0] SYNC_BYTE  = LDR_SYNC
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic        [7:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              prog_mode,
   output logic        [7:0] prog_addr,
   output trit_t       [8:0] prog_data,
   output logic              prog_we,
   output logic              load_done,
   output logic              load_error,
   output logic        [7:0] words_loaded
);

   localparam logic [8:0] DEPTH_LIMIT = 9'(IMEM_DEPTH);

   loader_state_t state_q, state_d;
   logic          prog_mode_q, prog_mode_d;
   logic    [7:0] prog_addr_q, prog_addr_d;
   trit_t   [8:0] prog_data_q, prog_data_d;
   logic          prog_we_q, prog_we_d;
   logic          load_done_q, load_done_d;
   logic          load_error_q, load_error_d;
   logic    [7:0] words_q, words_d;
   logic    [7:0] count_q, count_d;
   logic    [7:0] csum_q, csum_d;
   logic    [7:0] byte0_q, byte0_d;
   logic    [7:0] byte1_q, byte1_d;

   logic          accept;
   logic    [3:0] rx_fields_ok;
   logic          rx_byte_ok;
   logic    [7:0] words_inc;
   trit_t   [8:0] unpack_word;
   logic          unpack_err;

   // Per-field trit legality of the incoming byte, used while in B0/B1.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rx_field
         assign rx_fields_ok[gi] = trit_code_valid(rx_data[2*gi +: 2]);
      end
   endgenerate

   assign rx_byte_ok = &rx_fields_ok;
   assign words_inc  = words_q + 8'd1;

   // The third byte is unpacked straight off the bus so the word registers on acceptance.
   ternary_insn_unpack u_unpack (
      .byte0   (byte0_q),
      .byte1   (byte1_q),
      .byte2   (rx_data),
      .word    (unpack_word),
      .fmt_err (unpack_err)
   );

   // Back-pressure only while writing or signalling frame end; the source holds its byte.
   always_comb begin
      rx_ready = 1'b1;
      if (state_q == LDR_WR || state_q == LDR_DONE || state_q == LDR_ERR) begin
         rx_ready = 1'b0;
      end
   end

   assign accept = rx_valid & rx_ready;

   // Frame parser next-state and datapath.
   always_comb begin
      state_d      = state_q;
      prog_mode_d  = prog_mode_q;
      prog_addr_d  = prog_addr_q;
      prog_data_d  = prog_data_q;
      prog_we_d    = 1'b0;
      load_done_d  = 1'b0;
      load_error_d = load_error_q;
      words_d      = words_q;
      count_d      = count_q;
      csum_d       = csum_q;
      byte0_d      = byte0_q;
      byte1_d      = byte1_q;

      case (state_q)
         LDR_IDLE: begin
            if (accept && rx_data == SYNC_BYTE) begin
               state_d      = LDR_CNT;
               prog_mode_d  = 1'b1;
               load_error_d = 1'b0;
               words_d      = 8'd0;
               prog_addr_d  = 8'd0;
               csum_d       = 8'd0;
            end
         end
         LDR_CNT: begin
            if (accept) begin
               if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_LIMIT) begin
                  state_d      = LDR_ERR;
                  load_error_d = 1'b1;
                  prog_mode_d  = 1'b0;
               end else begin
                  count_d = rx_data;
                  csum_d  = rx_data;
                  state_d = LDR_B0;
               end
            end
         end
         LDR_B0, LDR_B1: begin
            if (accept) begin
               csum_d = csum_q ^ rx_data;
               if (!rx_byte_ok) begin
                  state_d      = LDR_ERR;
                  load_error_d = 1'b1;
                  prog_mode_d  = 1'b0;
               end else if (state_q == LDR_B0) begin
                  byte0_d = rx_data;
                  state_d = LDR_B1;
               end else begin
                  byte1_d = rx_data;
                  state_d = LDR_B2;
               end
            end
         end
         LDR_B2: begin
            if (accept) begin
               csum_d = csum_q ^ rx_data;
               if (unpack_err) begin
                  state_d      = LDR_ERR;
                  load_error_d = 1'b1;
                  prog_mode_d  = 1'b0;
               end else begin
                  prog_data_d = unpack_word;
                  prog_we_d   = 1'b1;
                  state_d     = LDR_WR;
               end
            end
         end
         LDR_WR: begin
            // prog_we is high this cycle at prog_addr_q; advance for the next word.
            prog_addr_d = prog_addr_q + 8'd1;
            words_d     = words_inc;
            state_d     = (words_inc == count_q) ? LDR_CSUM : LDR_B0;
         end
         LDR_CSUM: begin
            if (accept) begin
               prog_mode_d = 1'b0;
               if (rx_data == csum_q) begin
                  state_d     = LDR_DONE;
                  load_done_d = 1'b1;
               end else begin
                  state_d      = LDR_ERR;
                  load_error_d = 1'b1;
               end
            end
         end
         LDR_DONE, LDR_ERR: begin
            state_d = LDR_IDLE;
         end
         default: begin
            state_d     = LDR_IDLE;
            prog_mode_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset returns everything to idle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LDR_IDLE;
         prog_mode_q  <= 1'b0;
         prog_addr_q  <= 8'd0;
         prog_data_q  <= {9{T_ZERO}};
         prog_we_q    <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         words_q      <= 8'd0;
         count_q      <= 8'd0;
         csum_q       <= 8'd0;
         byte0_q      <= 8'd0;
         byte1_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         prog_mode_q  <= prog_mode_d;
         prog_addr_q  <= prog_addr_d;
         prog_data_q  <= prog_data_d;
         prog_we_q    <= prog_we_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
         words_q      <= words_d;
         count_q      <= count_d;
         csum_q       <= csum_d;
         byte0_q      <= byte0_d;
         byte1_q      <= byte1_d;
      end
   end

   assign prog_mode    = prog_mode_q;
   assign prog_addr    = prog_addr_q;
   assign prog_data    = prog_data_q;
   assign prog_we      = prog_we_q;
   assign load_done    = load_done_q;
   assign load_error   = load_error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_ternary_prog_loader.sv
// Self-checking bench for ternary_prog_loader: directed and random frames
// checked against a whole-frame reference parser.
module tb_ternary_prog_loader;
   import ternary_pkg::*;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic  [7:0] rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        prog_mode;
   logic  [7:0] prog_addr;
   logic [17:0] prog_data;
   logic        prog_we;
   logic        load_done;
   logic        load_error;
   logic  [7:0] words_loaded;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   ternary_prog_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .prog_mode    (prog_mode),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .prog_we      (prog_we),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record every write strobe and done pulse, sampled mid-cycle.
   logic [25:0] got_wr[$];
   int          got_cyc[$];
   int          n_done = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (prog_we) begin
            got_wr.push_back({prog_addr, prog_data});
            got_cyc.push_back(cyc);
         end
         if (load_done) n_done = n_done + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: parse a whole frame and predict writes, outcome and bytes consumed.
   logic [25:0] exp_wr[$];
   bit          exp_ok;
   int          exp_len;

   function automatic bit field_ok(input logic [1:0] f);
      return (f == T_ZERO) || (f == T_POS_ONE) || (f == T_NEG_ONE);
   endfunction

   function automatic bit byte_bad(input logic [7:0] b, input int k);
      if (k == 2) return (b[7:2] != 6'd0) || !field_ok(b[1:0]);
      for (int i = 0; i < 4; i++) begin
         if (!field_ok(b[2*i +: 2])) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model(input bq_t fr);
      int p = 0;
      logic [7:0] n, cs;
      logic [7:0] b[3];
      exp_wr.delete();
      exp_ok = 1'b0;
      while (p < fr.size() && fr[p] != 8'hA5) p++;
      p++;
      n = fr[p];
      p++;
      cs = n;
      if (n == 8'd0 || n > 8'd243) begin
         exp_len = p;
         return;
      end
      for (int w = 0; w < int'(n); w++) begin
         for (int k = 0; k < 3; k++) begin
            b[k] = fr[p];
            p++;
            cs = cs ^ b[k];
            if (byte_bad(b[k], k)) begin
               exp_len = p;
               return;
            end
         end
         exp_wr.push_back({8'(w), b[2][1:0], b[1], b[0]});
      end
      exp_ok  = (fr[p] == cs);
      exp_len = p + 1;
   endfunction

   // Frame construction.
   bq_t frm;

   function automatic logic [7:0] rnd_byte(input int k);
      logic [1:0] codes[3];
      logic [7:0] b = 8'd0;
      codes[0] = T_ZERO;
      codes[1] = T_POS_ONE;
      codes[2] = T_NEG_ONE;
      for (int i = 0; i < ((k == 2) ? 1 : 4); i++) begin
         b[2*i +: 2] = codes[$urandom_range(0, 2)];
      end
      return b;
   endfunction

   // kind: 0 good, 1 bad checksum, 2 stray byte2 upper bits, 3 illegal trit code
   function automatic void build(input int n, input int kind, input int ngarb);
      logic [7:0] b, cs;
      int bw, bk;
      frm.delete();
      for (int g = 0; g < ngarb; g++) begin
         do b = 8'($urandom); while (b == 8'hA5);
         frm.push_back(b);
      end
      frm.push_back(8'hA5);
      frm.push_back(8'(n));
      cs = 8'(n);
      if (n >= 1 && n <= 243) begin
         bw = $urandom_range(0, n - 1);
         bk = (kind == 2) ? 2 : $urandom_range(0, 2);
         for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 3; k++) begin
               b = rnd_byte(k);
               if (w == bw && k == bk) begin
                  if (kind == 2) b = b | (8'h04 << $urandom_range(0, 5));
                  if (kind == 3) b = b | (8'h03 << (2 * ((k == 2) ? 0 : $urandom_range(0, 3))));
               end
               frm.push_back(b);
               cs = cs ^ b;
            end
         end
         frm.push_back((kind == 1) ? (cs ^ (8'h01 << $urandom_range(0, 7))) : cs);
      end
   endfunction

   // Offer one byte (optionally after idle gaps) and return once it is accepted.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int budget = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!rx_ready) check_eq("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic run_frame(input string name, input int ngarb, input bit gaps, input bit gap_chk);
      int wr_base = got_wr.size();
      int done_base = n_done;
      int nw;
      bq_t fr = frm;
      model(fr);
      for (int i = 0; i < exp_len; i++) begin
         if (i > ngarb) check_eq("mode_hold", 32'(prog_mode), 32'd1);
         send_byte(fr[i], gaps);
         if (i == ngarb) begin
            check_eq("mode_on", 32'(prog_mode), 32'd1);
            check_eq("err_clr", 32'(load_error), 32'd0);
         end
      end
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      nw = got_wr.size() - wr_base;
      check_eq("n_writes", 32'(nw), 32'(exp_wr.size()));
      for (int i = 0; i < nw && i < exp_wr.size(); i++) begin
         check_eq("write", 32'(got_wr[wr_base + i]), 32'(exp_wr[i]));
      end
      if (gap_chk) check_eq("we_spacing", 32'(got_cyc[wr_base + 1] - got_cyc[wr_base]), 32'd4);
      check_eq("done", 32'(n_done - done_base), 32'(exp_ok));
      check_eq("error", 32'(load_error), 32'(!exp_ok));
      check_eq("words", 32'(words_loaded), 32'(exp_wr.size()));
      check_eq("mode_off", 32'(prog_mode), 32'd0);
      check_eq("ready_idle", 32'(rx_ready), 32'd1);
      $display("frame %s: bytes=%0d writes=%0d/%0d ok=%0d err=%0d", name, exp_len, nw,
               exp_wr.size(), exp_ok, load_error);
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_ready"}, 32'(rx_ready), 32'd1);
      check_eq({tag, "_mode"}, 32'(prog_mode), 32'd0);
      check_eq({tag, "_addr"}, 32'(prog_addr), 32'd0);
      check_eq({tag, "_data"}, 32'(prog_data), 32'd0);
      check_eq({tag, "_we"}, 32'(prog_we), 32'd0);
      check_eq({tag, "_done"}, 32'(load_done), 32'd0);
      check_eq({tag, "_error"}, 32'(load_error), 32'd0);
      check_eq({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin
      int n, kind;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("post_rst");

      // Single all-zero word, garbage before sync.
      frm.delete();
      frm.push_back(8'h11); frm.push_back(8'h22);
      frm.push_back(8'hA5); frm.push_back(8'h01);
      frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h00);
      frm.push_back(8'h01);
      run_frame("one_zero_word", 2, 1'b0, 1'b0);

      // Two words back to back: writes four cycles apart.
      build(2, 0, 0);
      run_frame("two_words", 0, 1'b0, 1'b1);
      build(2, 1, 0);
      run_frame("two_words_bad_csum", 0, 1'b0, 1'b0);
      build(3, 0, 0);
      run_frame("after_error", 0, 1'b1, 1'b0);

      build(0, 0, 0);
      run_frame("count_0", 0, 1'b0, 1'b0);
      build(244, 0, 0);
      run_frame("count_244", 0, 1'b0, 1'b0);
      build(243, 0, 0);
      run_frame("count_243", 0, 1'b0, 1'b0);
      check_eq("last_addr", 32'(got_wr[got_wr.size() - 1][25:18]), 32'd242);

      build(2, 2, 0);
      run_frame("byte2_upper", 0, 1'b0, 1'b0);
      build(2, 3, 0);
      run_frame("bad_trit", 0, 1'b0, 1'b0);

      // Reset while waiting for byte1.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      check_eq("mode_before_rst", 32'(prog_mode), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      rx_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      build(4, 0, 1);
      run_frame("post_reset_gaps", 1, 1'b1, 1'b0);

      // Random frames with random gaps.
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0:       n = 0;
            1:       n = $urandom_range(244, 255);
            default: n = $urandom_range(1, 6);
         endcase
         build(n, kind, $urandom_range(0, 2));
         run_frame($sformatf("rand%0d_n%0d_k%0d", t, n, kind), frm.size() - ((n >= 1 && n <= 243) ? 3 * n + 3 : 2),
                   1'b1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
